// File: rtl/serv_dbus_ram8_pkg.sv
// -----------------------------------------------------------------------------
// serv_dbus_ram8_pkg
//   Shared definitions for the SERV data-bus to byte-wide SRAM responder:
//   FSM state encoding, lane count and the request-to-ack latencies.
//   Also holds a small helper that picks one byte lane out of a word.
// -----------------------------------------------------------------------------
package serv_dbus_ram8_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_BUSY_ENC  = 2'd1;
  localparam logic [1:0] ST_DRAIN_ENC = 2'd2;
  localparam logic [1:0] ST_ACK_ENC   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_BUSY  = ST_BUSY_ENC,
    ST_DRAIN = ST_DRAIN_ENC,
    ST_ACK   = ST_ACK_ENC
  } state_e;

  // One 32-bit word is moved as four byte accesses
  localparam int LANES  = 4;
  localparam int LANE_W = 2;

  // Cycles from the request cycle (cycle 0) to the ack cycle
  localparam int LOAD_LATENCY  = 6;
  localparam int STORE_LATENCY = 5;

  // Select byte lane 'lane' of a 32-bit word
  function automatic logic [7:0] lane_byte(input logic [31:0] word,
                                           input logic [LANE_W-1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'd0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/serv_dbus_ram8.sv
// -----------------------------------------------------------------------------
// serv_dbus_ram8
//   Wishbone data-bus responder for the SERV core. Each word request is
//   serialised into four byte accesses on an 8-bit synchronous SRAM. Loads
//   assemble the full word before a single-cycle ack; stores only write the
//   lanes whose byte select is set.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_wb_adr/dat/sel/we   request address, store data, byte selects, direction
//   i_wb_cyc              request valid
//   o_wb_rdt, o_wb_ack    load data and single-cycle completion pulse
//   o_mem_addr/wdata      SRAM byte address and write byte
//   o_mem_en, o_mem_we    SRAM access enable and write enable
//   i_mem_rdata           SRAM read byte, one cycle after the enabled read
// -----------------------------------------------------------------------------
module serv_dbus_ram8
  import serv_dbus_ram8_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [31:0]   i_wb_adr,
  input  logic [31:0]   i_wb_dat,
  input  logic [3:0]    i_wb_sel,
  input  logic          i_wb_we,
  input  logic          i_wb_cyc,
  output logic [31:0]   o_wb_rdt,
  output logic          o_wb_ack,
  output logic [AW-1:0] o_mem_addr,
  output logic [7:0]    o_mem_wdata,
  output logic          o_mem_en,
  output logic          o_mem_we,
  input  logic [7:0]    i_mem_rdata
);

  state_e            r_state;
  logic [LANE_W-1:0] r_lane;
  logic [AW-3:0]     r_adr;
  logic [31:0]       r_dat;
  logic [3:0]        r_sel;
  logic              r_we;
  // Lower three bytes of a load; the top byte arrives in DRAIN and the
  // whole word is committed to r_wb_rdt only then, so an aborted load
  // leaves the previously returned word untouched.
  logic [23:0]       r_asm;
  logic [31:0]       r_wb_rdt;
  logic              r_wb_ack;

  logic [AW-1:0]     w_mem_addr;
  logic [7:0]        w_mem_wdata;
  logic              w_mem_en;
  logic              w_mem_we;

  // Upper address bits alias and the low two bits are word-aligned
  logic              w_unused_adr;
  assign w_unused_adr = ^{i_wb_adr[31:AW], i_wb_adr[1:0]};

  // Request FSM, lane counter, load assembly and registered bus outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_lane   <= {LANE_W{1'b0}};
      r_adr    <= {(AW-2){1'b0}};
      r_dat    <= 32'd0;
      r_sel    <= 4'd0;
      r_we     <= 1'b0;
      r_asm    <= 24'd0;
      r_wb_rdt <= 32'd0;
      r_wb_ack <= 1'b0;
    end else begin
      r_wb_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_wb_cyc) begin
            r_adr   <= i_wb_adr[AW-1:2];
            r_dat   <= i_wb_dat;
            r_sel   <= i_wb_sel;
            r_we    <= i_wb_we;
            r_lane  <= {LANE_W{1'b0}};
            r_state <= ST_BUSY;
          end
        end

        ST_BUSY: begin
          if (!i_wb_cyc) begin
            r_lane  <= {LANE_W{1'b0}};
            r_state <= ST_IDLE;
          end else begin
            // Read data lags the address by one cycle: lane N captures byte N-1
            if (!r_we) begin
              case (r_lane)
                2'd1:    r_asm[7:0]   <= i_mem_rdata;
                2'd2:    r_asm[15:8]  <= i_mem_rdata;
                2'd3:    r_asm[23:16] <= i_mem_rdata;
                default: r_asm        <= r_asm;
              endcase
            end
            r_lane <= r_lane + 2'd1;
            if (r_lane == 2'd3) begin
              if (r_we) begin
                r_wb_ack <= 1'b1;
                r_state  <= ST_ACK;
              end else begin
                r_state  <= ST_DRAIN;
              end
            end
          end
        end

        ST_DRAIN: begin
          if (!i_wb_cyc) begin
            r_state <= ST_IDLE;
          end else begin
            r_wb_rdt <= {i_mem_rdata, r_asm};
            r_wb_ack <= 1'b1;
            r_state  <= ST_ACK;
          end
        end

        ST_ACK: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // SRAM-side decode from registered state; quiet outside BUSY
  always_comb begin
    w_mem_addr  = {AW{1'b0}};
    w_mem_wdata = 8'd0;
    w_mem_en    = 1'b0;
    w_mem_we    = 1'b0;
    if (r_state == ST_BUSY) begin
      w_mem_addr = {r_adr, r_lane};
      if (r_we) begin
        // Unselected lanes still spend their cycle but do not touch the SRAM
        w_mem_en    = r_sel[r_lane];
        w_mem_we    = r_sel[r_lane];
        w_mem_wdata = lane_byte(r_dat, r_lane);
      end else begin
        w_mem_en    = 1'b1;
        w_mem_we    = 1'b0;
        w_mem_wdata = 8'd0;
      end
    end else begin
      w_mem_addr  = {AW{1'b0}};
      w_mem_wdata = 8'd0;
      w_mem_en    = 1'b0;
      w_mem_we    = 1'b0;
    end
  end

  assign o_wb_rdt    = r_wb_rdt;
  assign o_wb_ack    = r_wb_ack;
  assign o_mem_addr  = w_mem_addr;
  assign o_mem_wdata = w_mem_wdata;
  assign o_mem_en    = w_mem_en;
  assign o_mem_we    = w_mem_we;

endmodule

// File: tb/tb_serv_dbus_ram8.sv
// -----------------------------------------------------------------------------
// tb_serv_dbus_ram8
//   Directed bench for serv_dbus_ram8 with a behavioural byte-wide SRAM.
// -----------------------------------------------------------------------------
module tb_serv_dbus_ram8;
  import serv_dbus_ram8_pkg::*;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   wb_adr = 32'd0;
  logic [31:0]   wb_dat = 32'd0;
  logic [3:0]    wb_sel = 4'd0;
  logic          wb_we = 1'b0;
  logic          wb_cyc = 1'b0;
  logic [31:0]   wb_rdt;
  logic          wb_ack;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_en;
  logic          mem_we;
  logic [7:0]    mem_rdata = 8'd0;

  logic [7:0]    sram [0:(1<<AW)-1];

  int n_checks = 0;
  int n_fail   = 0;

  serv_dbus_ram8 #(.AW(AW)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_wb_adr    (wb_adr),
    .i_wb_dat    (wb_dat),
    .i_wb_sel    (wb_sel),
    .i_wb_we     (wb_we),
    .i_wb_cyc    (wb_cyc),
    .o_wb_rdt    (wb_rdt),
    .o_wb_ack    (wb_ack),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_mem_en    (mem_en),
    .o_mem_we    (mem_we),
    .i_mem_rdata (mem_rdata)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Synchronous byte SRAM: read data appears one cycle after an enabled read
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= sram[mem_addr];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Issue one request from an IDLE negedge; returns at the negedge after the ack cycle
  task automatic wb_xfer(input string tag, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel,
                         input logic [31:0] exp_rdt, input logic chk_mem);
    int ack_cyc;
    int lat;
    logic [AW-1:0] exp_addr;
    ack_cyc = -1;
    lat     = we ? STORE_LATENCY : LOAD_LATENCY;
    wb_we   = we;
    wb_adr  = adr;
    wb_dat  = dat;
    wb_sel  = sel;
    wb_cyc  = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (chk_mem && k <= 4) begin
        exp_addr = (adr[AW-1:0] & 12'hFFC) | 12'(k-1);
        if (we) begin
          check_val({tag, "_en"}, 32'(mem_en), 32'(sel[k-1]));
          check_val({tag, "_we"}, 32'(mem_we), 32'(sel[k-1]));
          if (sel[k-1]) begin
            check_val({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
            check_val({tag, "_wdata"}, 32'(mem_wdata), 32'(dat[8*(k-1) +: 8]));
          end
        end else begin
          check_val({tag, "_en"}, 32'(mem_en), 32'd1);
          check_val({tag, "_we"}, 32'(mem_we), 32'd0);
          check_val({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
        end
      end
      if (wb_ack) begin
        ack_cyc = k;
        break;
      end
    end
    check_val({tag, "_lat"}, 32'(ack_cyc), 32'(lat));
    if (!we && ack_cyc > 0) check_val({tag, "_rdt"}, wb_rdt, exp_rdt);
    wb_cyc = 1'b0;
    @(negedge clk);
    check_val({tag, "_ack1cyc"}, 32'(wb_ack), 32'd0);
  endtask

  logic seen_ack;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_ack", 32'(wb_ack), 32'd0);
    check_val("rst_rdt", wb_rdt, 32'd0);
    check_val("rst_mem", {20'd0, mem_addr}, 32'd0);
    check_val("rst_en_we_wd", {22'd0, mem_en, mem_we, mem_wdata}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full store then load
    wb_xfer("st_full", 1'b1, 32'h10, 32'hA1B2C3D4, 4'hF, 32'd0, 1'b1);
    check_val("sram_full", {sram[12'h13], sram[12'h12], sram[12'h11], sram[12'h10]}, 32'hA1B2C3D4);
    wb_xfer("ld_full", 1'b0, 32'h10, 32'd0, 4'hF, 32'hA1B2C3D4, 1'b1);

    // Partial store: only lane 2
    wb_xfer("st_part", 1'b1, 32'h10, 32'hFFEE1122, 4'b0100, 32'd0, 1'b1);
    wb_xfer("ld_part", 1'b0, 32'h10, 32'd0, 4'b0000, 32'hA1EEC3D4, 1'b0);

    // Address aliasing above AW
    wb_xfer("st_alias", 1'b1, 32'h1010, 32'h00000055, 4'h1, 32'd0, 1'b1);
    check_val("sram_alias", 32'(sram[12'h010]), 32'h55);
    wb_xfer("ld_alias", 1'b0, 32'h10, 32'd0, 4'hF, 32'hA1EEC355, 1'b0);

    // Reset in the middle of a store
    wb_xfer("st_pre20", 1'b1, 32'h20, 32'hDEADBEEF, 4'hF, 32'd0, 1'b0);
    @(negedge clk);
    wb_we = 1'b1; wb_adr = 32'h20; wb_dat = 32'h11223344; wb_sel = 4'hF; wb_cyc = 1'b1;
    @(negedge clk);
    check_val("rstmid_lane0_en", 32'(mem_en), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("rstmid_ack", 32'(wb_ack), 32'd0);
    check_val("rstmid_rdt", wb_rdt, 32'd0);
    check_val("rstmid_mem", {19'd0, mem_en, mem_addr}, 32'd0);
    check_val("rstmid_we_wd", {23'd0, mem_we, mem_wdata}, 32'd0);
    wb_cyc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen_ack = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (wb_ack) seen_ack = 1'b1;
    end
    check_val("rstmid_noack", 32'(seen_ack), 32'd0);
    wb_xfer("ld_after_rst", 1'b0, 32'h20, 32'd0, 4'hF, 32'hDEADBE44, 1'b0);

    // Abort a load in cycle 3
    wb_we = 1'b0; wb_adr = 32'h10; wb_sel = 4'hF; wb_cyc = 1'b1;
    repeat (3) @(negedge clk);
    wb_cyc = 1'b0;
    @(negedge clk);
    check_val("abort_idle_en", 32'(mem_en), 32'd0);
    seen_ack = wb_ack;
    repeat (6) begin
      @(negedge clk);
      if (wb_ack) seen_ack = 1'b1;
    end
    check_val("abort_noack", 32'(seen_ack), 32'd0);
    check_val("abort_rdt_kept", wb_rdt, 32'hDEADBE44);

    // Back-to-back: second store presented in the cycle after the first ack
    wb_xfer("st_b2b_a", 1'b1, 32'h30, 32'h01234567, 4'hF, 32'd0, 1'b0);
    wb_xfer("st_b2b_b", 1'b1, 32'h34, 32'h89ABCDEF, 4'hF, 32'd0, 1'b1);
    wb_xfer("ld_b2b_a", 1'b0, 32'h30, 32'd0, 4'hF, 32'h01234567, 1'b0);
    wb_xfer("ld_b2b_b", 1'b0, 32'h34, 32'd0, 4'hF, 32'h89ABCDEF, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
